// File: rtl/mem_client_pkg.sv
// mem_client_pkg: shared types and defaults for the memory client.
//   state_t : response FSM state (IDLE / LIVE / HELD)
//   src_t   : owner of the outstanding read response
//   GNT_*   : bit positions in the arbiter eligible/grant vectors
package mem_client_pkg;

  localparam int unsigned AW_DEFAULT = 16;
  localparam int unsigned DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    LIVE,
    HELD
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_IF,
    SRC_D
  } src_t;

  localparam int unsigned GNT_IF = 0;
  localparam int unsigned GNT_D  = 1;

endpackage

// File: rtl/mem_rr_arb.sv
// mem_rr_arb: 2-input round-robin arbiter (IF vs D).
//   clk, rst : clock, synchronous active-high reset
//   elig     : per-port eligibility (bit GNT_IF, bit GNT_D); already includes valid
//   grant    : one-hot grant; a grant is an accept, so it also advances the pointer
module mem_rr_arb
  import mem_client_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  output logic [1:0] grant
);

  // 1 when D was granted most recently; reset to IF so D wins the first tie.
  logic last_d_q;
  logic last_d_d;

  always_comb begin
    grant    = elig;
    last_d_d = last_d_q;
    if (elig == 2'b11) begin
      grant = last_d_q ? 2'b01 : 2'b10;
    end
    if (grant[GNT_D]) begin
      last_d_d = 1'b1;
    end else if (grant[GNT_IF]) begin
      last_d_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end

endmodule

// File: rtl/mem_client.sv
// mem_client: initiator-side controller for the single-write/dual-read
// synchronous CPU memory (registered reads, 1-cycle latency).
//   clk, rst                       : clock, synchronous active-high reset
//   if_req_* / if_rsp_*            : instruction fetch request / response (instr=mem[a], imm=mem[a+1])
//   d_req_* / d_rsp_*              : load/store request / load response
//   mem_wen, mem_waddr, mem_wdata  : memory write port
//   mem_raddr1/2, mem_rdata1/2     : memory read ports
// Reads are granted only when no response is outstanding or the outstanding
// one is consumed this cycle; stores can be granted in any state.
module mem_client
  import mem_client_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_req_addr,
  output logic          if_rsp_valid,
  input  logic          if_rsp_ready,
  output logic [DW-1:0] if_rsp_instr,
  output logic [DW-1:0] if_rsp_imm,

  input  logic          d_req_valid,
  output logic          d_req_ready,
  input  logic          d_req_we,
  input  logic [AW-1:0] d_req_addr,
  input  logic [DW-1:0] d_req_wdata,
  output logic          d_rsp_valid,
  input  logic          d_rsp_ready,
  output logic [DW-1:0] d_rsp_rdata,

  output logic          mem_wen,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr1,
  output logic [AW-1:0] mem_raddr2,
  input  logic [DW-1:0] mem_rdata1,
  input  logic [DW-1:0] mem_rdata2
);

  state_t        state_q, state_d;
  src_t          pend_src_q, pend_src_d;
  logic [DW-1:0] cap1_q, cap1_d;
  logic [DW-1:0] cap2_q, cap2_d;

  logic [1:0]    elig;
  logic [1:0]    grant;
  logic          rsp_done;
  logic          rd_free;
  logic          rd_acc;
  src_t          rd_src;
  logic          held;

  // Response side. Valids are gated by rst so nothing is presented while in reset.
  always_comb begin
    held         = (state_q == HELD);
    if_rsp_valid = ~rst & (state_q != IDLE) & (pend_src_q == SRC_IF);
    d_rsp_valid  = ~rst & (state_q != IDLE) & (pend_src_q == SRC_D);
    if_rsp_instr = held ? cap1_q : mem_rdata1;
    if_rsp_imm   = held ? cap2_q : mem_rdata2;
    d_rsp_rdata  = held ? cap1_q : mem_rdata1;
    rsp_done     = (if_rsp_valid & if_rsp_ready) | (d_rsp_valid & d_rsp_ready);
    rd_free      = (state_q == IDLE) | rsp_done;
  end

  // Eligibility includes valid, so a grant is an accept.
  always_comb begin
    elig         = '0;
    elig[GNT_IF] = ~rst & if_req_valid & rd_free;
    elig[GNT_D]  = ~rst & d_req_valid & (d_req_we | rd_free);
  end

  mem_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .elig  (elig),
    .grant (grant)
  );

  // Memory request side, combinational from the granted request.
  always_comb begin
    if_req_ready = grant[GNT_IF];
    d_req_ready  = grant[GNT_D];
    mem_wen      = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    mem_raddr1   = '0;
    mem_raddr2   = '0;
    rd_acc       = 1'b0;
    rd_src       = SRC_NONE;
    if (grant[GNT_IF]) begin
      mem_raddr1 = if_req_addr;
      mem_raddr2 = if_req_addr + AW'(1);
      rd_acc     = 1'b1;
      rd_src     = SRC_IF;
    end else if (grant[GNT_D]) begin
      if (d_req_we) begin
        mem_wen   = 1'b1;
        mem_waddr = d_req_addr;
        mem_wdata = d_req_wdata;
      end else begin
        mem_raddr1 = d_req_addr;
        rd_acc     = 1'b1;
        rd_src     = SRC_D;
      end
    end
  end

  // Response FSM.
  always_comb begin
    state_d    = state_q;
    pend_src_d = pend_src_q;
    cap1_d     = cap1_q;
    cap2_d     = cap2_q;
    unique case (state_q)
      IDLE: begin
        if (rd_acc) begin
          state_d    = LIVE;
          pend_src_d = rd_src;
        end
      end
      LIVE, HELD: begin
        if (rsp_done) begin
          if (rd_acc) begin
            state_d    = LIVE;
            pend_src_d = rd_src;
          end else begin
            state_d    = IDLE;
            pend_src_d = SRC_NONE;
          end
        end else if (state_q == LIVE) begin
          // Memory read data is only valid for one cycle; capture before it is lost.
          state_d = HELD;
          cap1_d  = mem_rdata1;
          cap2_d  = mem_rdata2;
        end
      end
      default: begin
        state_d    = IDLE;
        pend_src_d = SRC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_src_q <= SRC_NONE;
      cap1_q     <= '0;
      cap2_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_src_q <= pend_src_d;
      cap1_q     <= cap1_d;
      cap2_q     <= cap2_d;
    end
  end

endmodule

// File: tb/tb_mem_client.sv
// tb_mem_client: directed bench for mem_client with a behavioural memory and
// a response scoreboard (expected data queued on accept, compared on response).
module tb_mem_client;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_rsp_valid, if_rsp_ready;
  logic [DW-1:0] if_rsp_instr, if_rsp_imm;
  logic          d_req_valid, d_req_ready, d_req_we;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata;
  logic          d_rsp_valid, d_rsp_ready;
  logic [DW-1:0] d_rsp_rdata;
  logic          mem_wen;
  logic [AW-1:0] mem_waddr, mem_raddr1, mem_raddr2;
  logic [DW-1:0] mem_wdata, mem_rdata1, mem_rdata2;

  always #5 clk = ~clk;

  mem_client #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_ready (if_rsp_ready),
    .if_rsp_instr (if_rsp_instr),
    .if_rsp_imm   (if_rsp_imm),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_we     (d_req_we),
    .d_req_addr   (d_req_addr),
    .d_req_wdata  (d_req_wdata),
    .d_rsp_valid  (d_rsp_valid),
    .d_rsp_ready  (d_rsp_ready),
    .d_rsp_rdata  (d_rsp_rdata),
    .mem_wen      (mem_wen),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_raddr1   (mem_raddr1),
    .mem_raddr2   (mem_raddr2),
    .mem_rdata1   (mem_rdata1),
    .mem_rdata2   (mem_rdata2)
  );

  // Memory model: registered reads, read registers hold on write cycles.
  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_waddr] = mem_wdata;
    end else begin
      mem_rdata1 <= mem[mem_raddr1];
      mem_rdata2 <= mem[mem_raddr2];
    end
  end

  int checks   = 0;
  int failures = 0;
  logic [2*DW-1:0] if_q [$];
  logic [DW-1:0]   d_q  [$];
  logic            exp_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: sample at negedge (scoreboard compare + push on accept), then
  // return 1 time unit after the next posedge for the caller to drive inputs.
  task automatic cycle();
    logic [AW-1:0] a1;
    @(negedge clk);
    if (!rst) begin
      chk("rsp_exclusive", {31'd0, if_rsp_valid & d_rsp_valid}, 32'd0);
      if (if_rsp_valid) begin
        chk("if_rsp_expected", {31'd0, if_q.size() != 0}, 32'd1);
        if (if_q.size() != 0) begin
          chk("if_rsp_data", {if_rsp_instr, if_rsp_imm}, if_q[0]);
          if (if_rsp_ready) void'(if_q.pop_front());
        end
      end
      if (d_rsp_valid) begin
        chk("d_rsp_expected", {31'd0, d_q.size() != 0}, 32'd1);
        if (d_q.size() != 0) begin
          chk("d_rsp_data", {16'd0, d_rsp_rdata}, {16'd0, d_q[0]});
          if (d_rsp_ready) void'(d_q.pop_front());
        end
      end
      if (if_req_valid && if_req_ready) begin
        a1 = if_req_addr + 16'd1;
        if_q.push_back({ref_mem[if_req_addr], ref_mem[a1]});
      end
      if (d_req_valid && d_req_ready) begin
        if (d_req_we) ref_mem[d_req_addr] = d_req_wdata;
        else d_q.push_back(ref_mem[d_req_addr]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int unsigned i = 0; i < 65536; i++) begin
      mem[i]     = i[15:0] ^ 16'h5A5A;
      ref_mem[i] = i[15:0] ^ 16'h5A5A;
    end
    mem[16'hFFFF] = 16'hA001;  ref_mem[16'hFFFF] = 16'hA001;
    mem[16'h0000] = 16'h0002;  ref_mem[16'h0000] = 16'h0002;

    // Reset with requests pending: nothing may be granted or presented.
    rst          = 1'b1;
    if_req_valid = 1'b1;  if_req_addr = 16'h0005;  if_rsp_ready = 1'b1;
    d_req_valid  = 1'b1;  d_req_we    = 1'b1;      d_req_addr   = 16'h0005;
    d_req_wdata  = 16'hFFFF;  d_rsp_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    #1;
    chk("rst_if_req_ready", {31'd0, if_req_ready}, 32'd0);
    chk("rst_d_req_ready",  {31'd0, d_req_ready},  32'd0);
    chk("rst_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
    chk("rst_d_rsp_valid",  {31'd0, d_rsp_valid},  32'd0);
    chk("rst_mem_wen",      {31'd0, mem_wen},      32'd0);
    chk("rst_raddr1",       {16'd0, mem_raddr1},   32'd0);
    chk("rst_raddr2",       {16'd0, mem_raddr2},   32'd0);
    cycle();
    rst = 1'b0;  if_req_valid = 1'b0;  d_req_valid = 1'b0;

    // Store then load of the same address on consecutive edges.
    d_req_valid = 1'b1;  d_req_we = 1'b1;  d_req_addr = 16'h0040;  d_req_wdata = 16'h1234;
    #1;
    chk("st_ready", {31'd0, d_req_ready}, 32'd1);
    chk("st_wen",   {31'd0, mem_wen},     32'd1);
    chk("st_waddr", {16'd0, mem_waddr},   32'h0040);
    chk("st_wdata", {16'd0, mem_wdata},   32'h1234);
    cycle();
    d_req_we = 1'b0;
    #1;
    chk("ld_ready",  {31'd0, d_req_ready}, 32'd1);
    chk("st_no_rsp", {31'd0, d_rsp_valid}, 32'd0);
    chk("ld_raddr1", {16'd0, mem_raddr1},  32'h0040);
    cycle();
    d_req_valid = 1'b0;
    #1;
    chk("ld_rsp_valid", {31'd0, d_rsp_valid}, 32'd1);
    chk("ld_rsp_new",   {16'd0, d_rsp_rdata}, 32'h1234);
    cycle();

    // Fetch at the top of the address space wraps the second read address.
    if_req_valid = 1'b1;  if_req_addr = 16'hFFFF;
    #1;
    chk("wrap_ready",  {31'd0, if_req_ready}, 32'd1);
    chk("wrap_raddr1", {16'd0, mem_raddr1},   32'h0000_FFFF);
    chk("wrap_raddr2", {16'd0, mem_raddr2},   32'h0000_0000);
    cycle();
    if_req_valid = 1'b0;
    #1;
    chk("wrap_instr", {16'd0, if_rsp_instr}, 32'h0000_A001);
    chk("wrap_imm",   {16'd0, if_rsp_imm},   32'h0000_0002);
    cycle();

    // Back-to-back loads: one accept and one response per cycle.
    for (int unsigned i = 0; i < 4; i++) begin
      d_req_valid = 1'b1;  d_req_we = 1'b0;  d_req_addr = 16'h0100 + i[15:0];
      #1;
      chk("b2b_ready", {31'd0, d_req_ready}, 32'd1);
      if (i > 0) chk("b2b_rsp_valid", {31'd0, d_rsp_valid}, 32'd1);
      cycle();
    end
    d_req_valid = 1'b0;
    #1;
    chk("b2b_last_rsp", {31'd0, d_rsp_valid}, 32'd1);
    cycle();
    chk("b2b_drained", d_q.size(), 32'd0);

    // Backpressure: fetch held for 3 cycles while a store to the same address lands.
    if_rsp_ready = 1'b0;  if_req_valid = 1'b1;  if_req_addr = 16'h0010;
    #1;
    chk("bp_fetch_ready", {31'd0, if_req_ready}, 32'd1);
    cycle();
    if_req_addr = 16'h0020;
    d_req_valid = 1'b1;  d_req_we = 1'b1;  d_req_addr = 16'h0010;  d_req_wdata = 16'h5555;
    #1;
    chk("bp_if_blocked", {31'd0, if_req_ready}, 32'd0);
    chk("bp_st_ready",   {31'd0, d_req_ready},  32'd1);
    chk("bp_instr_old",  {16'd0, if_rsp_instr}, 32'h0000_5A4A);
    chk("bp_imm_old",    {16'd0, if_rsp_imm},   32'h0000_5A4B);
    cycle();
    d_req_valid = 1'b0;
    repeat (2) begin
      #1;
      chk("bp_if_blocked", {31'd0, if_req_ready}, 32'd0);
      chk("bp_rsp_held",   {31'd0, if_rsp_valid}, 32'd1);
      cycle();
    end
    if_rsp_ready = 1'b1;
    #1;
    chk("bp_consume_accept", {31'd0, if_req_ready}, 32'd1);
    cycle();

    // Reset while a response is held: it must never appear.
    if_req_valid = 1'b0;  if_rsp_ready = 1'b0;
    cycle();
    #1;
    chk("held_before_rst", {31'd0, if_rsp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drop_if_valid", {31'd0, if_rsp_valid}, 32'd0);
    cycle();
    if_q.delete();
    d_q.delete();
    rst = 1'b0;

    // Contention straight out of reset: D, IF, D, IF ... one accept per cycle.
    if_rsp_ready = 1'b1;  d_rsp_ready = 1'b1;
    if_req_valid = 1'b1;  d_req_valid = 1'b1;  d_req_we = 1'b0;
    exp_d = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if_req_addr = 16'h0200 + i[15:0];
      d_req_addr  = 16'h0300 + i[15:0];
      #1;
      chk("cont_d_ready",  {31'd0, d_req_ready},  {31'd0, exp_d});
      chk("cont_if_ready", {31'd0, if_req_ready}, {31'd0, ~exp_d});
      cycle();
      exp_d = ~exp_d;
    end
    if_req_valid = 1'b0;  d_req_valid = 1'b0;

    for (int unsigned n = 0; n < 8 && (if_q.size() + d_q.size()) != 0; n++) cycle();
    chk("final_if_drained", if_q.size(), 32'd0);
    chk("final_d_drained",  d_q.size(),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
